// File: rtl/divu_hilo_ctrl.sv
// Iterative restoring unsigned divider that owns the architectural HI/LO pair.
// It also stalls MFHI/MFLO in EX while a divide is in flight.
module divu_hilo_ctrl #(
  parameter int WIDTH      = 32,
  parameter int BITS_PER_C = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BITS_PER_C;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] rem_s [0:BITS_PER_C];
  logic [WIDTH-1:0] quo_s [0:BITS_PER_C];

  assign rem_s[0] = rem_q;
  assign quo_s[0] = quo_q;

  // The shifted partial remainder is WIDTH+1 bits; its top bit alone forces
  // rem >= div, and the true difference always fits back into WIDTH bits.
  generate
    for (genvar gi = 0; gi < BITS_PER_C; gi++) begin : g_step
      logic [WIDTH-1:0] shl;
      logic             ge;
      assign shl = {rem_s[gi][WIDTH-2:0], quo_s[gi][WIDTH-1]};
      assign ge  = rem_s[gi][WIDTH-1] | (shl >= div_q);
      assign rem_s[gi+1] = ge ? (shl - div_q) : shl;
      assign quo_s[gi+1] = {quo_s[gi][WIDTH-2:0], ge};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != '0) begin
            div_d   = divisor;
            rem_d   = '0;
            quo_d   = dividend;
            cnt_d   = CW'(N);
            dz_d    = 1'b0;
            state_d = RUN;
          end else begin
            lo_d    = '1;
            hi_d    = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = rem_s[BITS_PER_C];
        quo_d = quo_s[BITS_PER_C];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = rem_s[BITS_PER_C];
          lo_d    = quo_s[BITS_PER_C];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign dz      = dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign stall   = mf_req & (busy | start);
  assign mf_data = mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_divu_hilo_ctrl.sv
// Directed bench for divu_hilo_ctrl: vector table plus stall, reset-abort and
// two-bits-per-cycle sequences.
module tb_divu_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, mf_req, mf_sel;
  logic [31:0] dividend, divisor;
  logic [31:0] mf_data, hi, lo;
  logic        stall, busy, done, dz;

  logic        start2;
  logic [31:0] dividend2, divisor2;
  logic [31:0] mf_data2, hi2, lo2;
  logic        stall2, busy2, done2, dz2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divu_hilo_ctrl #(.WIDTH(32), .BITS_PER_C(1)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data), .stall(stall),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  divu_hilo_ctrl #(.WIDTH(32), .BITS_PER_C(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dividend(dividend2), .divisor(divisor2),
    .mf_req(1'b0), .mf_sel(1'b0), .mf_data(mf_data2), .stall(stall2),
    .busy(busy2), .done(done2), .dz(dz2), .hi(hi2), .lo(lo2)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dz;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one DIVU at the current (post-edge) time; returns the number of
  // edges after the start edge until done is seen, and busy just after start.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_seen);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    busy_seen = busy;
    lat       = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    int   cnt;
    logic bsy;
    logic ok;

    vecs[0] = '{32'd100,       32'd7,          32'd14,         32'd2,  1'b0};
    vecs[1] = '{32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   32'd0,  1'b0};
    vecs[2] = '{32'd5,         32'd9,          32'd0,          32'd5,  1'b0};
    vecs[3] = '{32'd42,        32'd0,          32'hFFFFFFFF,   32'd42, 1'b1};
    vecs[4] = '{32'd9,         32'd3,          32'd3,          32'd0,  1'b0};
    vecs[5] = '{32'd0,         32'd5,          32'd0,          32'd0,  1'b0};
    vecs[6] = '{32'hFFFFFFFF,  32'hFFFFFFFF,   32'd1,          32'd0,  1'b0};
    vecs[7] = '{32'h80000000,  32'd3,          32'h2AAAAAAA,   32'd2,  1'b0};
    vecs[8] = '{32'd1000,      32'd33,         32'd30,         32'd10, 1'b0};

    rst = 1'b0; start = 1'b0; mf_req = 1'b0; mf_sel = 1'b0;
    dividend = '0; divisor = '0;
    start2 = 1'b0; dividend2 = '0; divisor2 = '0;

    @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_dz", {31'd0, dz}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat, bsy);
      $display("txn %0d: %0d / %0d -> lo=0x%08h hi=0x%08h dz=%0b latency=%0d",
               i, vecs[i].a, vecs[i].b, lo, hi, dz, lat);
      check($sformatf("v%0d_latency", i), lat, (vecs[i].b == 0) ? 32'd0 : 32'd32);
      check($sformatf("v%0d_busy", i), {31'd0, bsy}, {31'd0, vecs[i].b != 0});
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].exp_dz});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // MF held across a divide: stall in the start cycle and every RUN cycle.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    mf_req   = 1'b1;
    mf_sel   = 1'b1;
    #1;
    check("stall_start_mf", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    ok    = 1'b1;
    cnt   = 0;
    while (!done && cnt < 200) begin
      if (!stall || hi !== 32'd10) ok = 1'b0;
      @(posedge clk);
      #1;
      cnt++;
    end
    $display("txn stall: 100 / 7 with MFHI held, run cycles=%0d", cnt);
    check("stall_run_cycles", cnt, 32'd32);
    check("stall_all_run_hi_held", {31'd0, ok}, 32'd1);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("mf_hi_done", mf_data, 32'd2);
    mf_sel = 1'b0;
    #1;
    check("mf_lo_done", mf_data, 32'd14);
    mf_req = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the tenth RUN cycle aborts without commit or done pulse.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    cnt = 0;
    repeat (40) begin
      if (done) cnt++;
      @(posedge clk);
      #1;
    end
    $display("txn abort: 100 / 7 reset mid-run, done pulses=%0d", cnt);
    check("abort_no_done", cnt, 32'd0);
    run_div(32'd8, 32'd2, lat, bsy);
    $display("txn %0d / %0d after abort -> lo=0x%08h hi=0x%08h", 8, 2, lo, hi);
    check("after_abort_latency", lat, 32'd32);
    check("after_abort_lo", lo, 32'd4);
    check("after_abort_hi", hi, 32'd0);
    @(posedge clk);
    #1;

    // Two quotient bits per cycle.
    for (int j = 0; j < 2; j++) begin
      logic [31:0] a2, b2, el, eh;
      a2 = (j == 0) ? 32'd100 : 32'hFFFFFFFF;
      b2 = (j == 0) ? 32'd7   : 32'd3;
      el = (j == 0) ? 32'd14  : 32'h55555555;
      eh = (j == 0) ? 32'd2   : 32'd0;
      dividend2 = a2;
      divisor2  = b2;
      start2    = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      cnt    = 0;
      while (!done2 && cnt < 200) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      $display("txn bpc2 %0d: %0d / %0d -> lo=0x%08h hi=0x%08h latency=%0d",
               j, a2, b2, lo2, hi2, cnt);
      check($sformatf("bpc2_%0d_latency", j), cnt, 32'd16);
      check($sformatf("bpc2_%0d_lo", j), lo2, el);
      check($sformatf("bpc2_%0d_hi", j), hi2, eh);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
